// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, RV32 opcode constants, EX/MEM payload layout
// and the EX/MEM register occupancy states.
package pipeline_pkg;

    localparam int unsigned XlenDefault = 32;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    typedef struct packed {
        logic [6:0]             opcode;
        logic [2:0]             funct3;
        logic [4:0]             rd;
        logic [XlenDefault-1:0] alu_result;
        logic [XlenDefault-1:0] store_data;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} em_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload + valid holding element; clear has priority over load and zeroes the payload
// so that control bits read as 0 whenever the slot is empty.
module pipe_skid_slot #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/execute_memory_register.sv
// EX/MEM pipeline register with valid/ready handshake, flush and forwarding tap.
// Define EXMEM_SKID_EN for a registered ready_o backed by a one-entry skid slot.
module execute_memory_register
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [6:0]      em_opcode_o,
    output logic [2:0]      em_funct3_o,
    output logic [4:0]      em_rd_o,
    output logic [XLEN-1:0] em_alu_result_o,
    output logic [XLEN-1:0] em_store_data_o,
    output logic            em_reg_write_o,
    output logic            em_mem_read_o,
    output logic            em_mem_write_o,
    output logic            fwd_valid_o,
    output logic [4:0]      fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o
);

    localparam int unsigned PayloadW = $bits(ex_mem_payload_t);

    ex_mem_payload_t in_pl, out_pl, out_din;
    em_state_e       state;
    logic            out_valid, out_load, out_clear;
    logic            accept, transfer;

    assign in_pl.opcode     = opcode_i;
    assign in_pl.funct3     = funct3_i;
    assign in_pl.rd         = rd_i;
    assign in_pl.alu_result = alu_result_i;
    assign in_pl.store_data = store_data_i;
    assign in_pl.reg_write  = reg_write_i;
    assign in_pl.mem_read   = mem_read_i;
    assign in_pl.mem_write  = mem_write_i;

    assign accept   = valid_i && ready_o;
    assign transfer = out_valid && ready_i;

`ifdef EXMEM_SKID_EN
    ex_mem_payload_t skid_pl;
    logic            skid_valid, skid_load, skid_clear, out_sel_skid;

    // ready_o comes straight from a flop, so ready_i never reaches it combinationally.
    assign ready_o = !skid_valid;
    assign state   = skid_valid ? StSkid : (out_valid ? StFull : StEmpty);
    assign out_din = out_sel_skid ? skid_pl : in_pl;

    always_comb begin
        out_load     = 1'b0;
        out_clear    = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        out_sel_skid = 1'b0;
        if (flush_i) begin
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                StEmpty: out_load = accept;
                StFull: begin
                    if (accept && transfer) out_load  = 1'b1;
                    else if (accept)        skid_load = 1'b1;
                    else if (transfer)      out_clear = 1'b1;
                end
                StSkid: begin
                    if (transfer) begin
                        out_load     = 1'b1;
                        out_sel_skid = 1'b1;
                        skid_clear   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_skid_slot #(
        .Width (PayloadW)
    ) u_skid_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .data_i  (in_pl),
        .valid_o (skid_valid),
        .data_o  (skid_pl)
    );
`else
    assign ready_o = ready_i || !out_valid;
    assign state   = out_valid ? StFull : StEmpty;
    assign out_din = in_pl;

    always_comb begin
        out_load  = 1'b0;
        out_clear = 1'b0;
        if (flush_i) begin
            out_clear = 1'b1;
        end else begin
            unique case (state)
                StEmpty: out_load = accept;
                StFull: begin
                    if (accept)        out_load  = 1'b1;
                    else if (transfer) out_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end
`endif

    pipe_skid_slot #(
        .Width (PayloadW)
    ) u_out_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (out_clear),
        .load_i  (out_load),
        .data_i  (out_din),
        .valid_o (out_valid),
        .data_o  (out_pl)
    );

    assign valid_o         = out_valid;
    assign em_opcode_o     = out_pl.opcode;
    assign em_funct3_o     = out_pl.funct3;
    assign em_rd_o         = out_pl.rd;
    assign em_alu_result_o = out_pl.alu_result;
    assign em_store_data_o = out_pl.store_data;
    assign em_reg_write_o  = out_pl.reg_write;
    assign em_mem_read_o   = out_pl.mem_read;
    assign em_mem_write_o  = out_pl.mem_write;

    // Loads produce their value in MEM, so they are not a forwarding source here.
    assign fwd_valid_o = out_valid && out_pl.reg_write && !out_pl.mem_read && (out_pl.rd != 5'd0);
    assign fwd_rd_o    = out_pl.rd;
    assign fwd_data_o  = out_pl.alu_result;

endmodule

// File: tb/tb_execute_memory_register.sv
// Directed and randomised handshake checks for execute_memory_register; expectations hold
// whether or not EXMEM_SKID_EN is defined.
module tb_execute_memory_register;
    import pipeline_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni, flush_i, valid_i, ready_o, ready_i, valid_o;
    logic [6:0]      opcode_i, em_opcode_o;
    logic [2:0]      funct3_i, em_funct3_o;
    logic [4:0]      rd_i, em_rd_o, fwd_rd_o;
    logic [XLEN-1:0] alu_result_i, store_data_i, em_alu_result_o, em_store_data_o, fwd_data_o;
    logic            reg_write_i, mem_read_i, mem_write_i;
    logic            em_reg_write_o, em_mem_read_o, em_mem_write_o, fwd_valid_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    execute_memory_register #(
        .XLEN (XLEN)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .opcode_i        (opcode_i),
        .funct3_i        (funct3_i),
        .rd_i            (rd_i),
        .alu_result_i    (alu_result_i),
        .store_data_i    (store_data_i),
        .reg_write_i     (reg_write_i),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .em_opcode_o     (em_opcode_o),
        .em_funct3_o     (em_funct3_o),
        .em_rd_o         (em_rd_o),
        .em_alu_result_o (em_alu_result_o),
        .em_store_data_o (em_store_data_o),
        .em_reg_write_o  (em_reg_write_o),
        .em_mem_read_o   (em_mem_read_o),
        .em_mem_write_o  (em_mem_write_o),
        .fwd_valid_o     (fwd_valid_o),
        .fwd_rd_o        (fwd_rd_o),
        .fwd_data_o      (fwd_data_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [4:0] rd, input logic [31:0] res,
                         input logic rw, input logic mr, input logic mw);
        valid_i      = 1'b1;
        opcode_i     = opc;
        funct3_i     = 3'd2;
        rd_i         = rd;
        alu_result_i = res;
        store_data_i = ~res;
        reg_write_i  = rw;
        mem_read_i   = mr;
        mem_write_i  = mw;
    endtask

    // Advance one clock; inputs held since the last edge, valid_i dropped once accepted.
    task automatic cycle();
        logic acc;
        #3;
        acc = valid_i && ready_o;
        @(posedge clk_i);
        #1;
        if (acc) valid_i = 1'b0;
    endtask

    logic [31:0] sb_q[$];
    logic [31:0] hold_res, seq;
    logic        acc, xfer, hold;

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        drive(OpcOp, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        valid_i = 1'b0;
        #12;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_memw", em_mem_write_o, 0);
        check("rst_fwd", fwd_valid_o, 0);
        check("rst_alu", em_alu_result_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // single pass with forwarding
        ready_i = 1'b1;
        drive(OpcOp, 5'd5, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
        cycle();
        check("pass_valid", valid_o, 1);
        check("pass_rd", em_rd_o, 5);
        check("pass_fwd_valid", fwd_valid_o, 1);
        check("pass_fwd_data", fwd_data_o, 32'hA5);
        check("pass_fwd_rd", fwd_rd_o, 5);
        check("pass_sdata", em_store_data_o, 32'hFFFF_FF5A);
        cycle();
        check("pass_drain", valid_o, 0);
        check("pass_drain_rw", em_reg_write_o, 0);

        // forwarding gated for loads and x0
        drive(OpcLoad, 5'd7, 32'h1000, 1'b1, 1'b1, 1'b0);
        cycle();
        check("load_valid", valid_o, 1);
        check("load_memr", em_mem_read_o, 1);
        check("load_fwd", fwd_valid_o, 0);
        drive(OpcOp, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0);
        cycle();
        check("x0_valid", valid_o, 1);
        check("x0_fwd", fwd_valid_o, 0);
        cycle();
        check("gate_drain", valid_o, 0);

        // backpressure: two items, output held, then released in order
        ready_i = 1'b0;
        drive(OpcOp, 5'd1, 32'h11, 1'b1, 1'b0, 1'b0);
        check("bp_ready_empty", ready_o, 1);
        cycle();
        check("bp_first", em_alu_result_o, 32'h11);
        drive(OpcOp, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
        cycle();
        check("bp_hold1", em_alu_result_o, 32'h11);
        check("bp_ready_full", ready_o, 0);
        cycle();
        check("bp_hold2", em_alu_result_o, 32'h11);
        check("bp_hold2_valid", valid_o, 1);
        ready_i = 1'b1;
        cycle();
        check("bp_second_valid", valid_o, 1);
        check("bp_second", em_alu_result_o, 32'h22);
        cycle();
        check("bp_drain", valid_o, 0);

        // flush with a simultaneous valid input
        ready_i = 1'b0;
        drive(OpcStore, 5'd0, 32'h33, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(OpcStore, 5'd0, 32'h44, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(OpcStore, 5'd0, 32'h55, 1'b0, 1'b0, 1'b1);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl_valid", valid_o, 0);
        check("fl_ready", ready_o, 1);
        check("fl_memw", em_mem_write_o, 0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("fl_nothing", valid_o, 0);
        end

        // asynchronous reset while holding an item
        ready_i = 1'b0;
        drive(OpcStore, 5'd0, 32'h66, 1'b0, 1'b0, 1'b1);
        cycle();
        check("ar_pre_valid", valid_o, 1);
        check("ar_pre_memw", em_mem_write_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_ready", ready_o, 1);
        check("ar_memw", em_mem_write_o, 0);
        check("ar_alu", em_alu_result_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        drive(OpcOp, 5'd3, 32'h77, 1'b1, 1'b0, 1'b0);
        cycle();
        check("ar_after_valid", valid_o, 1);
        check("ar_after_alu", em_alu_result_o, 32'h77);
        cycle();

        // random handshake: in-order delivery and stability under stall
        seq = 32'h100;
        for (int c = 0; c < 3010; c++) begin
            if (c < 3000) begin
                if (!valid_i && $urandom_range(0, 2) != 0) begin
                    drive(OpcOp, seq[4:0], seq, 1'b1, 1'b0, 1'b0);
                    seq = seq + 1;
                end
                ready_i = ($urandom_range(0, 1) != 0);
            end else begin
                ready_i = 1'b1;
            end
            #3;
            acc  = valid_i && ready_o;
            xfer = valid_o && ready_i;
            hold = valid_o && !ready_i;
            hold_res = em_alu_result_o;
            if (acc) sb_q.push_back(alu_result_i);
            if (xfer) begin
                if (sb_q.size() == 0) check("rnd_spurious", 1, 0);
                else begin
                    check("rnd_order", em_alu_result_o, sb_q[0]);
                    void'(sb_q.pop_front());
                end
            end
            @(posedge clk_i);
            #1;
            if (acc) valid_i = 1'b0;
            if (hold) begin
                check("rnd_stable_valid", valid_o, 1);
                check("rnd_stable_data", em_alu_result_o, hold_res);
            end
        end
        check("rnd_left", sb_q.size(), 0);
        check("rnd_end_valid", valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
